alu_issue_unit: RTL and testbench

- Sequential initiator and result collector for the 16-bit combinational ALU in the multi-cycle datapath.
- Accepts one operation request (funct3, A, B, destination tag) over a valid/ready handshake and registers the operands.
- Drives the ALU's funct3/A/B inputs from those registers and captures ALUOUT and cmp into the ALUOUT register stage.
- Presents the tagged result to writeback over a second valid/ready handshake.

---
 rtl/alu_issue_unit_if.sv | 82 ++++++++
 rtl/alu_issue_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_if.sv
// ---------------------------------------------------------------------------
// alu_issue_unit_if
//
// Purpose: bundles the three buses of the ALU issue unit into one interface.
//   - request handshake (issuer -> unit): operation select, operands, tag
//   - ALU drive/return (unit <-> combinational ALU)
//   - result handshake (unit -> writeback): captured result, cmp, tag
//
// Modports:
//   slave  : seen by alu_issue_unit (accepts requests, drives ALU, presents results)
//   master : seen by the environment (issuer, ALU and writeback side)
//
// Optional feature macro: ALU_ISSUE_BRANCH_EN adds the branch request fields
// (reqIsBranch, reqPc, reqImm) and branch result fields (resTaken, resTarget).
// ---------------------------------------------------------------------------
interface alu_issue_unit_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
);

  // Request handshake
  logic             reqValid;
  logic             reqReady;
  logic [2:0]       reqFunct3;
  logic [WIDTH-1:0] reqA;
  logic [WIDTH-1:0] reqB;
  logic [TAG_W-1:0] reqTag;

  // ALU drive and return
  logic [2:0]       aluFunct3;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [WIDTH-1:0] aluOut;
  logic             aluCmp;

  // Result handshake
  logic             resValid;
  logic             resReady;
  logic [WIDTH-1:0] resValue;
  logic             resCmp;
  logic [TAG_W-1:0] resTag;

`ifdef ALU_ISSUE_BRANCH_EN
  // Branch request fields and branch result fields
  logic             reqIsBranch;
  logic [WIDTH-1:0] reqPc;
  logic [WIDTH-1:0] reqImm;
  logic             resTaken;
  logic [WIDTH-1:0] resTarget;
`endif

  // The issue unit's view of the buses
  modport slave (
    input  reqValid, reqFunct3, reqA, reqB, reqTag,
    output reqReady,
    output aluFunct3, aluA, aluB,
    input  aluOut, aluCmp,
    output resValid, resValue, resCmp, resTag,
    input  resReady
`ifdef ALU_ISSUE_BRANCH_EN
    ,
    input  reqIsBranch, reqPc, reqImm,
    output resTaken, resTarget
`endif
  );

  // The environment's view of the buses
  modport master (
    output reqValid, reqFunct3, reqA, reqB, reqTag,
    input  reqReady,
    input  aluFunct3, aluA, aluB,
    output aluOut, aluCmp,
    input  resValid, resValue, resCmp, resTag,
    output resReady
`ifdef ALU_ISSUE_BRANCH_EN
    ,
    output reqIsBranch, reqPc, reqImm,
    input  resTaken, resTarget
`endif
  );

endinterface

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Purpose: sequential initiator and result collector for the 16-bit
// combinational ALU of the multi-cycle datapath. One request is accepted,
// its operands are registered and drive the ALU for one cycle, the ALU
// result and cmp flag are captured into the result stage, and the tagged
// result is offered to writeback.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   synchronous active-low reset
//   i_flush   abort any in-flight operation (forces IDLE, drops res valid)
//   o_busy    high while an operation is in EXEC or waiting in DONE
//   bus       alu_issue_unit_if.slave: request, ALU and result buses
//
// Optional feature macro: ALU_ISSUE_BRANCH_EN latches branch PC/offset with
// the request and produces a taken flag and a wrapped branch target along
// with the result.
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  output logic                 o_busy,
  alu_issue_unit_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;

  // Operand registers: they drive the ALU directly and keep their value
  // until the next accept, so a flush leaves them untouched.
  logic [2:0]       r_opFunct3;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [TAG_W-1:0] r_opTag;

  // Result registers
  logic             r_resValid;
  logic [WIDTH-1:0] r_resValue;
  logic             r_resCmp;
  logic [TAG_W-1:0] r_resTag;

`ifdef ALU_ISSUE_BRANCH_EN
  logic             r_opIsBranch;
  logic [WIDTH-1:0] r_opPc;
  logic [WIDTH-1:0] r_opImm;
  logic             r_resTaken;
  logic [WIDTH-1:0] r_resTarget;
`endif

  logic             w_reqReady;
  logic             w_accept;

  // A new request can enter when the unit is empty, or when the result in
  // DONE is being consumed this same edge (back-to-back issue). Flush blocks
  // acceptance so an aborted cycle never starts new work.
  assign w_reqReady = !i_flush &&
                      ((r_state == IDLE) || ((r_state == DONE) && bus.resReady));
  assign w_accept   = bus.reqValid && w_reqReady;

  // Main control and datapath registers. Operand latching is done on any
  // accept, independent of which state allowed it; the case statement only
  // decides the next state and the result stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_opFunct3   <= '0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_opTag      <= '0;
      r_resValid   <= 1'b0;
      r_resValue   <= '0;
      r_resCmp     <= 1'b0;
      r_resTag     <= '0;
`ifdef ALU_ISSUE_BRANCH_EN
      r_opIsBranch <= 1'b0;
      r_opPc       <= '0;
      r_opImm      <= '0;
      r_resTaken   <= 1'b0;
      r_resTarget  <= '0;
`endif
    end else if (i_flush) begin
      r_state    <= IDLE;
      r_resValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opFunct3   <= bus.reqFunct3;
        r_opA        <= bus.reqA;
        r_opB        <= bus.reqB;
        r_opTag      <= bus.reqTag;
`ifdef ALU_ISSUE_BRANCH_EN
        r_opIsBranch <= bus.reqIsBranch;
        r_opPc       <= bus.reqPc;
        r_opImm      <= bus.reqImm;
`endif
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= EXEC;
          end
        end

        EXEC: begin
          r_resValue  <= bus.aluOut;
          r_resCmp    <= bus.aluCmp;
          r_resTag    <= r_opTag;
`ifdef ALU_ISSUE_BRANCH_EN
          r_resTaken  <= bus.aluCmp && r_opIsBranch;
          r_resTarget <= r_opPc + r_opImm;
`endif
          r_resValid  <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          // Without resReady everything holds, keeping res_* stable.
          if (bus.resReady) begin
            r_resValid <= 1'b0;
            r_state    <= w_accept ? EXEC : IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_resValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reqReady  = w_reqReady;

  assign bus.aluFunct3 = r_opFunct3;
  assign bus.aluA      = r_opA;
  assign bus.aluB      = r_opB;

  assign bus.resValid  = r_resValid;
  assign bus.resValue  = r_resValue;
  assign bus.resCmp    = r_resCmp;
  assign bus.resTag    = r_resTag;

`ifdef ALU_ISSUE_BRANCH_EN
  assign bus.resTaken  = r_resTaken;
  assign bus.resTarget = r_resTarget;
`endif

  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
//
// Directed bench for alu_issue_unit. A small behavioural ALU answers the
// unit's alu_* outputs; expected results are hand-computed constants.
// Compile with ALU_ISSUE_BRANCH_EN defined to add the branch vector.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

  localparam int WIDTH = 16;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rstN;
  logic flush;
  logic busy;

  int total = 0;
  int bad   = 0;

  alu_issue_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) busIf ();

  alu_issue_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_flush (flush),
    .o_busy  (busy),
    .bus     (busIf)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra;
  // cmp keyed on funct3[1:0]: eq, ne, signed lt, signed ge.
  always_comb begin
    busIf.aluOut = '0;
    busIf.aluCmp = 1'b0;
    case (busIf.aluFunct3)
      3'd0: busIf.aluOut = busIf.aluA + busIf.aluB;
      3'd1: busIf.aluOut = busIf.aluA - busIf.aluB;
      3'd2: busIf.aluOut = busIf.aluA ^ busIf.aluB;
      3'd3: busIf.aluOut = busIf.aluA | busIf.aluB;
      3'd4: busIf.aluOut = busIf.aluA & busIf.aluB;
      3'd5: busIf.aluOut = busIf.aluA << busIf.aluB[3:0];
      3'd6: busIf.aluOut = busIf.aluA >> busIf.aluB[3:0];
      default: busIf.aluOut = WIDTH'($signed(busIf.aluA) >>> busIf.aluB[3:0]);
    endcase
    case (busIf.aluFunct3[1:0])
      2'd0: busIf.aluCmp = (busIf.aluA == busIf.aluB);
      2'd1: busIf.aluCmp = (busIf.aluA != busIf.aluB);
      2'd2: busIf.aluCmp = ($signed(busIf.aluA) < $signed(busIf.aluB));
      default: busIf.aluCmp = ($signed(busIf.aluA) >= $signed(busIf.aluB));
    endcase
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then drop reqValid.
  task automatic applyStimulus(input logic [2:0] f, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tg);
    busIf.reqFunct3 = f;
    busIf.reqA      = a;
    busIf.reqB      = b;
    busIf.reqTag    = tg;
    busIf.reqValid  = 1'b1;
    tick();
    busIf.reqValid  = 1'b0;
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got hang expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rstN            = 1'b0;
    flush           = 1'b0;
    busIf.reqValid  = 1'b0;
    busIf.reqFunct3 = '0;
    busIf.reqA      = '0;
    busIf.reqB      = '0;
    busIf.reqTag    = '0;
    busIf.resReady  = 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
    busIf.reqIsBranch = 1'b0;
    busIf.reqPc       = '0;
    busIf.reqImm      = '0;
`endif

    // Reset for two edges
    tick();
    tick();
    checkOutput("rst_resValid", 32'(busIf.resValid), 32'd0);
    checkOutput("rst_resValue", 32'(busIf.resValue), 32'd0);
    checkOutput("rst_resCmp",   32'(busIf.resCmp),   32'd0);
    checkOutput("rst_resTag",   32'(busIf.resTag),   32'd0);
    checkOutput("rst_aluA",     32'(busIf.aluA),     32'd0);
    checkOutput("rst_busy",     32'(busy),           32'd0);
    checkOutput("rst_reqReady", 32'(busIf.reqReady), 32'd1);
    rstN = 1'b1;

    // Add: 5 + 7
    applyStimulus(3'd0, 16'd5, 16'd7, 5'd3);
    checkOutput("add_aluA",     32'(busIf.aluA),     32'd5);
    checkOutput("add_aluB",     32'(busIf.aluB),     32'd7);
    checkOutput("add_busy",     32'(busy),           32'd1);
    checkOutput("add_exValid",  32'(busIf.resValid), 32'd0);
    checkOutput("add_exReady",  32'(busIf.reqReady), 32'd0);
    tick();
    checkOutput("add_valid",    32'(busIf.resValid), 32'd1);
    checkOutput("add_value",    32'(busIf.resValue), 32'd12);
    checkOutput("add_cmp",      32'(busIf.resCmp),   32'd0);
    checkOutput("add_tag",      32'(busIf.resTag),   32'd3);
    busIf.resReady = 1'b1;
    tick();
    checkOutput("add_idleValid", 32'(busIf.resValid), 32'd0);
    checkOutput("add_idleBusy",  32'(busy),           32'd0);

    // Arithmetic shift right: -16 >>> 2, cmp -16 >= 2 false
    applyStimulus(3'd7, 16'hFFF0, 16'd2, 5'd9);
    tick();
    checkOutput("sra_value", 32'(busIf.resValue), 32'h0000FFFC);
    checkOutput("sra_cmp",   32'(busIf.resCmp),   32'd0);
    checkOutput("sra_tag",   32'(busIf.resTag),   32'd9);
    tick();

    // And: 0x00FF & 0x00FF, cmp eq
    applyStimulus(3'd4, 16'h00FF, 16'h00FF, 5'd1);
    tick();
    checkOutput("and_value", 32'(busIf.resValue), 32'h000000FF);
    checkOutput("and_cmp",   32'(busIf.resCmp),   32'd1);
    tick();

    // Writeback stall for three cycles, then back-to-back issue
    busIf.resReady = 1'b0;
    applyStimulus(3'd0, 16'd100, 16'd23, 5'd4);
    tick();
    checkOutput("hold_value0", 32'(busIf.resValue), 32'd123);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_value", 32'(busIf.resValue), 32'd123);
      checkOutput("hold_tag",   32'(busIf.resTag),   32'd4);
      checkOutput("hold_valid", 32'(busIf.resValid), 32'd1);
      checkOutput("hold_ready", 32'(busIf.reqReady), 32'd0);
    end
    busIf.resReady  = 1'b1;
    busIf.reqFunct3 = 3'd1;
    busIf.reqA      = 16'd10;
    busIf.reqB      = 16'd3;
    busIf.reqTag    = 5'd6;
    busIf.reqValid  = 1'b1;
    #1;
    checkOutput("b2b_ready", 32'(busIf.reqReady), 32'd1);
    tick();
    busIf.reqValid = 1'b0;
    checkOutput("b2b_exValid", 32'(busIf.resValid), 32'd0);
    checkOutput("b2b_busy",    32'(busy),           32'd1);
    checkOutput("b2b_aluA",    32'(busIf.aluA),     32'd10);
    tick();
    checkOutput("b2b_value", 32'(busIf.resValue), 32'd7);
    checkOutput("b2b_cmp",   32'(busIf.resCmp),   32'd1);
    checkOutput("b2b_tag",   32'(busIf.resTag),   32'd6);
    tick();

    // Flush in EXEC
    applyStimulus(3'd0, 16'd1, 16'd1, 5'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_valid", 32'(busIf.resValid), 32'd0);
    checkOutput("flush_busy",  32'(busy),           32'd0);
    checkOutput("flush_aluA",  32'(busIf.aluA),     32'd1);
    tick();
    checkOutput("flush_valid2", 32'(busIf.resValid), 32'd0);

    // Flush with a request in IDLE: no accept
    flush           = 1'b1;
    busIf.reqFunct3 = 3'd0;
    busIf.reqA      = 16'd50;
    busIf.reqValid  = 1'b1;
    #1;
    checkOutput("flushReq_ready", 32'(busIf.reqReady), 32'd0);
    tick();
    flush          = 1'b0;
    busIf.reqValid = 1'b0;
    checkOutput("flushReq_busy", 32'(busy),       32'd0);
    checkOutput("flushReq_aluA", 32'(busIf.aluA), 32'd1);

    // Reset while in DONE, then a normal request
    busIf.resReady = 1'b0;
    applyStimulus(3'd0, 16'd2, 16'd3, 5'd5);
    tick();
    checkOutput("rstDone_pre", 32'(busIf.resValue), 32'd5);
    rstN = 1'b0;
    tick();
    checkOutput("rstDone_valid", 32'(busIf.resValid), 32'd0);
    checkOutput("rstDone_value", 32'(busIf.resValue), 32'd0);
    checkOutput("rstDone_tag",   32'(busIf.resTag),   32'd0);
    checkOutput("rstDone_aluA",  32'(busIf.aluA),     32'd0);
    checkOutput("rstDone_busy",  32'(busy),           32'd0);
    checkOutput("rstDone_ready", 32'(busIf.reqReady), 32'd1);
    rstN = 1'b1;
    busIf.resReady = 1'b1;
    applyStimulus(3'd3, 16'd6, 16'd1, 5'd7);
    tick();
    checkOutput("post_valid", 32'(busIf.resValid), 32'd1);
    checkOutput("post_value", 32'(busIf.resValue), 32'd7);
    checkOutput("post_cmp",   32'(busIf.resCmp),   32'd1);
    checkOutput("post_tag",   32'(busIf.resTag),   32'd7);
    tick();

`ifdef ALU_ISSUE_BRANCH_EN
    // Branch: -1 < 1 taken, target 0xFFF8 + 0x0010 wraps to 0x0008
    busIf.reqIsBranch = 1'b1;
    busIf.reqPc       = 16'hFFF8;
    busIf.reqImm      = 16'h0010;
    applyStimulus(3'd2, 16'hFFFF, 16'd1, 5'd8);
    busIf.reqIsBranch = 1'b0;
    tick();
    checkOutput("br_value",  32'(busIf.resValue),  32'h0000FFFE);
    checkOutput("br_taken",  32'(busIf.resTaken),  32'd1);
    checkOutput("br_target", 32'(busIf.resTarget), 32'h00000008);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
